// File: rtl/abc_seq_gen_pkg.sv
// abc_seq_gen_pkg: shared state/fault types and repeat-field width for the a/b/c sequence generator
package abc_seq_gen_pkg;
  localparam int REP_W = 4;
  typedef enum logic [2:0] {IDLE, SA, SB, SC, GAP} abc_state_e;
  typedef enum logic [1:0] {FAULT_NONE, FAULT_DROP_B, FAULT_DROP_C, FAULT_RSVD} abc_fault_e;
endpackage

// File: rtl/abc_seq_gen_if.sv
// abc_seq_gen_if: request port plus a/b/c protocol and status signals of abc_seq_gen
// Ports (master = generator side): req_valid/req_repeat/req_gap/req_fault in, req_ready out;
//   a/b/c/busy/done/seq_cnt out. The slave modport is the requester/checker side.
interface abc_seq_gen_if #(
  parameter int CNT_W = 16,
  parameter int GAP_W = 4
);
  import abc_seq_gen_pkg::*;
  logic             req_valid;
  logic             req_ready;
  logic [REP_W-1:0] req_repeat;
  logic [GAP_W-1:0] req_gap;
  logic [1:0]       req_fault;
  logic             a;
  logic             b;
  logic             c;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] seq_cnt;
  modport master (
    input  req_valid, req_repeat, req_gap, req_fault,
    output req_ready, a, b, c, busy, done, seq_cnt
  );
  modport slave (
    output req_valid, req_repeat, req_gap, req_fault,
    input  req_ready, a, b, c, busy, done, seq_cnt
  );
endinterface

// File: rtl/abc_seq_gen.sv
// abc_seq_gen: drives a, then b, then c on consecutive cycles for each accepted request
// Ports: clk; rst_n (async, active-low); bus (abc_seq_gen_if.master) carrying the
//   valid/ready request (repeat, gap, fault) and the registered a/b/c, busy, done, seq_cnt.
// Optional: define ABC_SEQ_GEN_FAULT_INJ_EN to honour req_fault (01 drop b, 10 drop c).
module abc_seq_gen
  import abc_seq_gen_pkg::*;
#(
  parameter int CNT_W = 16,
  parameter int GAP_W = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  abc_seq_gen_if.master bus
);
  abc_state_e       state_q, state_d;
  logic [REP_W-1:0] rep_q, rep_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [GAP_W-1:0] gcnt_q, gcnt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             a_q, a_d;
  logic             b_q, b_d;
  logic             c_q, c_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;
  logic             accept;
  logic             drop_b;
  logic             drop_c;
  assign accept = state_q == IDLE && bus.req_valid;
`ifdef ABC_SEQ_GEN_FAULT_INJ_EN
  abc_fault_e fault_q, fault_d;
  assign fault_d = accept ? abc_fault_e'(bus.req_fault) : fault_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) fault_q <= FAULT_NONE;
    else fault_q <= fault_d;
  assign drop_b = fault_q == FAULT_DROP_B;
  assign drop_c = fault_q == FAULT_DROP_C;
`else
  logic unused_fault;
  assign unused_fault = ^bus.req_fault;
  assign drop_b = 1'b0;
  assign drop_c = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    rep_d   = rep_q;
    gap_d   = gap_q;
    gcnt_d  = gcnt_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: if (accept) begin
        state_d = SA;
        rep_d   = bus.req_repeat;
        gap_d   = bus.req_gap;
      end
      SA: state_d = SB;
      SB: state_d = SC;
      SC: begin
        cnt_d = &cnt_q ? cnt_q : cnt_q + 1'b1;
        if (rep_q != '0) begin
          rep_d   = rep_q - 1'b1;
          gcnt_d  = gap_q;
          state_d = gap_q != '0 ? GAP : SA;
        end else
          state_d = IDLE;
      end
      GAP: begin
        gcnt_d  = gcnt_q - 1'b1;
        state_d = gcnt_q == GAP_W'(1) ? SA : GAP;
      end
      default: state_d = IDLE;
    endcase
    // outputs are registered from the next state so they line up with the state they describe
    a_d    = state_d == SA;
    b_d    = state_d == SB && !drop_b;
    c_d    = state_d == SC && !drop_c;
    done_d = state_d == SC && rep_q == '0;
    busy_d = state_d != IDLE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      rep_q   <= '0;
      gap_q   <= '0;
      gcnt_q  <= '0;
      cnt_q   <= '0;
      a_q     <= 1'b0;
      b_q     <= 1'b0;
      c_q     <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rep_q   <= rep_d;
      gap_q   <= gap_d;
      gcnt_q  <= gcnt_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  assign bus.req_ready = state_q == IDLE;
  assign bus.a         = a_q;
  assign bus.b         = b_q;
  assign bus.c         = c_q;
  assign bus.done      = done_q;
  assign bus.busy      = busy_q;
  assign bus.seq_cnt   = cnt_q;
endmodule

// File: tb/tb_abc_seq_gen.sv
// tb_abc_seq_gen: randomized self-checking bench for abc_seq_gen against a per-cycle list model
module tb_abc_seq_gen;
  localparam int CNT_W = 16;
  localparam int GAP_W = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int checks = 0;
  int passed = 0;
  int prop_pass = 0;
  int prop_fail = 0;
  int acc_cnt = 0;
  logic a1 = 1'b0;
  logic a2 = 1'b0;
  logic b1 = 1'b0;
  logic [4:0] exp_q[$];
  logic [5:0] obs_q[$];
  int cnt_m = 0;
  int pp_m = 0;
  int pf_m = 0;
  int p0, f0;
  abc_seq_gen_if #(.CNT_W(CNT_W), .GAP_W(GAP_W)) bus ();
  abc_seq_gen #(.CNT_W(CNT_W), .GAP_W(GAP_W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  // checker for a |-> ##1 b ##1 c, plus an acceptance counter
  always @(posedge clk) begin
    prop_pass <= prop_pass + int'(a2 && b1 && bus.c);
    prop_fail <= prop_fail + int'(a1 && !bus.b) + int'(a2 && b1 && !bus.c);
    acc_cnt   <= acc_cnt + int'(bus.req_valid && bus.req_ready);
    a2 <= a1;
    a1 <= bus.a;
    b1 <= bus.b;
  end
  // expected {a,b,c,done,busy} per cycle from acceptance through the first idle cycle
  function automatic void model(input int rep, input int gap, input int fault);
    int f = fault == 3 ? 0 : fault;
`ifndef ABC_SEQ_GEN_FAULT_INJ_EN
    f = 0;
`endif
    for (int s = 0; s <= rep; s++) begin
      exp_q.push_back(5'b10001);
      exp_q.push_back(f == 1 ? 5'b00001 : 5'b01001);
      exp_q.push_back({2'b00, f != 2, s == rep, 1'b1});
      if (s < rep) for (int g = 0; g < gap; g++) exp_q.push_back(5'b00001);
    end
    exp_q.push_back(5'b00000);
    cnt_m = cnt_m + rep + 1 > CNT_MAX ? CNT_MAX : cnt_m + rep + 1;
    if (f == 0) pp_m += rep + 1;
    else pf_m += rep + 1;
  endfunction
  function automatic void start(input int dummy);
    exp_q.delete();
    pp_m = dummy;
    pf_m = dummy;
    p0 = prop_pass;
    f0 = prop_fail;
  endfunction
  task automatic drive_req(input int rep, input int gap, input int fault);
    int w = 0;
    bus.req_valid  = 1'b1;
    bus.req_repeat = 4'(rep);
    bus.req_gap    = GAP_W'(gap);
    bus.req_fault  = 2'(fault);
    while (!bus.req_ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (w == 100) begin
      checks++;
      $display("FAIL accept_timeout: req_ready=%b required 1", bus.req_ready);
    end
    obs_q.delete();
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge clk);
      if (i == 0) bus.req_valid = 1'b0;
      obs_q.push_back({bus.req_ready, bus.a, bus.b, bus.c, bus.done, bus.busy});
    end
  endtask
  task automatic test_reset();
    bus.req_valid = 1'b0;
    bus.req_repeat = '0;
    bus.req_gap = '0;
    bus.req_fault = '0;
    #1 rst_n = 1'b0;
    #2;
    checks++;
    if ({bus.req_ready, bus.a, bus.b, bus.c, bus.done, bus.busy} !== 6'b100000)
      $display("FAIL reset_outputs: got %b required 100000", {bus.req_ready, bus.a, bus.b, bus.c, bus.done, bus.busy});
    else passed++;
    checks++;
    if (bus.seq_cnt !== '0) $display("FAIL reset_seq_cnt: got %0d required 0", bus.seq_cnt);
    else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    cnt_m = 0;
  endtask
  task automatic test_single();
    start(0);
    model(0, 0, 0);
    drive_req(0, 0, 0);
    foreach (exp_q[i]) begin
      checks++;
      if (obs_q[i] !== {~exp_q[i][0], exp_q[i]})
        $display("FAIL single_cyc%0d: got %b required %b", i, obs_q[i], {~exp_q[i][0], exp_q[i]});
      else passed++;
    end
    checks++;
    if (bus.seq_cnt !== CNT_W'(cnt_m)) $display("FAIL single_seq_cnt: got %0d required %0d", bus.seq_cnt, cnt_m);
    else passed++;
    checks++;
    if (prop_pass - p0 !== pp_m || prop_fail - f0 !== pf_m)
      $display("FAIL single_prop: pass/fail %0d/%0d required %0d/%0d", prop_pass - p0, prop_fail - f0, pp_m, pf_m);
    else passed++;
  endtask
  task automatic test_repeat();
    start(0);
    model(2, 0, 0);
    drive_req(2, 0, 0);
    foreach (exp_q[i]) begin
      checks++;
      if (obs_q[i] !== {~exp_q[i][0], exp_q[i]})
        $display("FAIL repeat_cyc%0d: got %b required %b", i, obs_q[i], {~exp_q[i][0], exp_q[i]});
      else passed++;
    end
    checks++;
    if (bus.seq_cnt !== CNT_W'(cnt_m)) $display("FAIL repeat_seq_cnt: got %0d required %0d", bus.seq_cnt, cnt_m);
    else passed++;
  endtask
  task automatic test_gap();
    int busy_n = 0;
    start(0);
    model(1, 3, 0);
    drive_req(1, 3, 0);
    foreach (exp_q[i]) begin
      busy_n += int'(obs_q[i][0]);
      checks++;
      if (obs_q[i] !== {~exp_q[i][0], exp_q[i]})
        $display("FAIL gap_cyc%0d: got %b required %b", i, obs_q[i], {~exp_q[i][0], exp_q[i]});
      else passed++;
    end
    checks++;
    if (busy_n !== (1 + 1) * 3 + 1 * 3) $display("FAIL gap_busy_cycles: got %0d required 9", busy_n);
    else passed++;
  endtask
  task automatic test_fault();
    for (int f = 1; f <= 3; f++) begin
      start(0);
      model(0, 0, f);
      drive_req(0, 0, f);
      foreach (exp_q[i]) begin
        checks++;
        if (obs_q[i] !== {~exp_q[i][0], exp_q[i]})
          $display("FAIL fault%0d_cyc%0d: got %b required %b", f, i, obs_q[i], {~exp_q[i][0], exp_q[i]});
        else passed++;
      end
      checks++;
      if (prop_pass - p0 !== pp_m || prop_fail - f0 !== pf_m)
        $display("FAIL fault%0d_prop: pass/fail %0d/%0d required %0d/%0d", f, prop_pass - p0, prop_fail - f0, pp_m, pf_m);
      else passed++;
      checks++;
      if (bus.seq_cnt !== CNT_W'(cnt_m)) $display("FAIL fault%0d_seq_cnt: got %0d required %0d", f, bus.seq_cnt, cnt_m);
      else passed++;
    end
  endtask
  task automatic test_random();
    for (int n = 0; n < 12; n++) begin
      int rep = $urandom_range(0, 15);
      int gap = $urandom_range(0, 3) == 0 ? 0 : $urandom_range(1, 15);
      int f = $urandom_range(0, 3);
      start(0);
      model(rep, gap, f);
      drive_req(rep, gap, f);
      foreach (exp_q[i]) begin
        checks++;
        if (obs_q[i] !== {~exp_q[i][0], exp_q[i]})
          $display("FAIL rand%0d_cyc%0d (rep %0d gap %0d fault %0d): got %b required %b", n, i, rep, gap, f, obs_q[i], {~exp_q[i][0], exp_q[i]});
        else passed++;
      end
      checks++;
      if (bus.seq_cnt !== CNT_W'(cnt_m)) $display("FAIL rand%0d_seq_cnt: got %0d required %0d", n, bus.seq_cnt, cnt_m);
      else passed++;
      checks++;
      if (prop_pass - p0 !== pp_m || prop_fail - f0 !== pf_m)
        $display("FAIL rand%0d_prop: pass/fail %0d/%0d required %0d/%0d", n, prop_pass - p0, prop_fail - f0, pp_m, pf_m);
      else passed++;
    end
  endtask
  task automatic test_reset_mid();
    bus.req_valid  = 1'b1;
    bus.req_repeat = 4'd3;
    bus.req_gap    = GAP_W'(2);
    bus.req_fault  = 2'd0;
    @(negedge clk);
    bus.req_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.b !== 1'b1) $display("FAIL rstmid_in_sb: b=%b required 1", bus.b);
    else passed++;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.req_ready, bus.a, bus.b, bus.c, bus.done, bus.busy} !== 6'b100000)
      $display("FAIL rstmid_outputs: got %b required 100000", {bus.req_ready, bus.a, bus.b, bus.c, bus.done, bus.busy});
    else passed++;
    checks++;
    if (bus.seq_cnt !== '0) $display("FAIL rstmid_seq_cnt: got %0d required 0", bus.seq_cnt);
    else passed++;
    cnt_m = 0;
    #2 rst_n = 1'b1;
    start(0);
    model(1, 0, 0);
    drive_req(1, 0, 0);
    foreach (exp_q[i]) begin
      checks++;
      if (obs_q[i] !== {~exp_q[i][0], exp_q[i]})
        $display("FAIL rstmid_restart_cyc%0d: got %b required %b", i, obs_q[i], {~exp_q[i][0], exp_q[i]});
      else passed++;
    end
    checks++;
    if (bus.seq_cnt !== CNT_W'(cnt_m)) $display("FAIL rstmid_restart_seq_cnt: got %0d required %0d", bus.seq_cnt, cnt_m);
    else passed++;
  endtask
  task automatic test_back_to_back();
    int acc0 = acc_cnt;
    start(0);
    model(0, 0, 0);
    model(1, 1, 0);
    bus.req_valid  = 1'b1;
    bus.req_repeat = 4'd0;
    bus.req_gap    = GAP_W'(0);
    bus.req_fault  = 2'd0;
    obs_q.delete();
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge clk);
      if (i == 0) begin
        bus.req_repeat = 4'd1;
        bus.req_gap    = GAP_W'(1);
      end
      if (i == 4) bus.req_valid = 1'b0;
      obs_q.push_back({bus.req_ready, bus.a, bus.b, bus.c, bus.done, bus.busy});
    end
    foreach (exp_q[i]) begin
      checks++;
      if (obs_q[i] !== {~exp_q[i][0], exp_q[i]})
        $display("FAIL b2b_cyc%0d: got %b required %b", i, obs_q[i], {~exp_q[i][0], exp_q[i]});
      else passed++;
    end
    checks++;
    if (acc_cnt - acc0 !== 2) $display("FAIL b2b_acceptances: got %0d required 2", acc_cnt - acc0);
    else passed++;
    checks++;
    if (bus.seq_cnt !== CNT_W'(cnt_m)) $display("FAIL b2b_seq_cnt: got %0d required %0d", bus.seq_cnt, cnt_m);
    else passed++;
  endtask
  initial begin
    test_reset();
    test_single();
    test_repeat();
    test_gap();
    test_fault();
    test_random();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/abc_seq_gen.md
# abc_seq_gen

Stimulus generator that drives the three-signal handshake `a`, then `b` one cycle later, then `c` one cycle after that, i.e. the sequence checked by the `a |-> ##1 b ##1 c` property. It sits on the driving side of the a/b/c interface in block-level benches and in loopback self-test. It accepts sequence requests over a valid/ready port and emits one or more back-to-back or gapped sequences. Optionally it injects protocol faults so the matching checker can be exercised.

## Interface
Parameters:
- `CNT_W`, 16: width of the completed-sequence counter.
- `GAP_W`, 4: width of the inter-sequence gap field.

Ports:
- `clk`  in  1: sole clock; all logic on posedge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `req_valid`  in  1: request present.
- `req_ready`  out  1: generator can accept a request.
- `req_repeat`  in  4: number of sequences to emit, minus 1 (0 → 1 sequence, 15 → 16).
- `req_gap`  in  GAP_W: idle cycles between consecutive sequences of one request.
- `req_fault`  in  2: fault command; 00 normal, 01 drop b, 10 drop c, 11 reserved (treated as 00).
- `a`, `b`, `c`  out  1 each: protocol outputs, registered.
- `busy`  out  1: high whenever state ≠ IDLE.
- `done`  out  1: one-cycle pulse coincident with the final `c` cycle of a request.
- `seq_cnt`  out  CNT_W: count of completed sequences, saturating.

## Operation
- FSM states: IDLE, SA, SB, SC, GAP.
- IDLE: `req_ready`=1. On `req_valid && req_ready`, latch `req_repeat`, `req_gap` and `req_fault`, then go to SA.
- SA: `a`=1. Go to SB.
- SB: `b`=1 unless the latched fault is 01. Go to SC.
- SC:
  - `c`=1 unless the latched fault is 10.
  - `seq_cnt` increments, saturating at all-ones, including for faulted sequences.
  - If repeats remain: go to GAP when gap>0, otherwise go directly to SA.
  - If no repeats remain: assert `done` and go to IDLE.
- GAP: all of a/b/c are 0. A down-counter is loaded with `req_gap` and counts to 1, then the FSM goes to SA.
- At most one of a/b/c is high in any cycle. No overlapping sequences.
- Inputs are sampled only at acceptance. Request fields changing while busy have no effect.
- `req_ready` is low in every state except IDLE. A `req_valid` arriving while busy is held off, not dropped; the requester must keep it asserted.

## Timing
- Reset values: `a`=`b`=`c`=0, `done`=0, `busy`=0, `req_ready`=1, `seq_cnt`=0, state IDLE.
- Acceptance at edge N:
  - `a` is high during cycle N+1 and is sampled by a checker at edge N+1.
  - `b` is high during cycle N+2.
  - `c` and `done` are high during cycle N+3 for a single sequence.
  - `req_ready` returns at N+4, so the earliest next acceptance is edge N+4.
- Repeated sequences: each sequence is 3 cycles plus `req_gap`. With gap 0, the next `a` immediately follows `c`.
- Total busy cycles for one request: (repeat+1)·3 + repeat·gap.
- Reset asserted mid-sequence: all outputs clear asynchronously, the FSM returns to IDLE, and the latched request is discarded. After release, the first acceptance is possible at the first edge.
- `seq_cnt` at all-ones stays at all-ones.

## Configuration
- Macro `ABC_SEQ_GEN_FAULT_INJ_EN`.
- Defined: `req_fault` is honoured as described above.
- Undefined: the `req_fault` port remains but is ignored, and the fault-latch register is not built. Every sequence is a normal a→b→c.

## Structure
- Package `abc_seq_gen_pkg` contains:
  - the state enum `abc_state_e` (IDLE, SA, SB, SC, GAP);
  - the fault enum `abc_fault_e` (FAULT_NONE, FAULT_DROP_B, FAULT_DROP_C, FAULT_RSVD);
  - the localparam for the repeat-field width (4).
- The repeat and gap counters stay inline. No sub-module is required; the block is a single FSM plus counters.

## Test plan
- Single normal request (repeat=0, gap=0, fault=00) accepted at 15 ns with a 10 ns clock:
  - `a` sampled high at 25 ns, `b` at 35 ns, `c` and `done` at 45 ns;
  - `seq_cnt`=1;
  - checker property passes once.
- Request with repeat=2, gap=0: pattern a,b,c,a,b,c,a,b,c in 9 consecutive cycles, one `done` on the last `c`, `seq_cnt`=3.
- Request with repeat=1, gap=3: a,b,c, then 3 idle cycles, then a,b,c; `busy` high for 9 cycles.
- With `ABC_SEQ_GEN_FAULT_INJ_EN`:
  - fault=01 makes the checker fail with offending `b`, one cycle after `a`;
  - fault=10 makes it fail with offending `c`;
  - `seq_cnt` still increments.
- Without the macro, fault=01 yields a normal sequence and the checker passes.
- Reset pulse during SB: a/b/c are 0 immediately, `req_ready`=1 after release, and a new request restarts cleanly from SA. Also hold `req_valid` high while busy and confirm exactly one extra acceptance, at the first cycle after returning to IDLE.
